// File: rtl/fifo_stream_reader_pkg.sv
// Shared helpers for the FIFO stream reader: width rule for occupancy counters.
package fifo_stream_reader_pkg;

    function automatic int count_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus valid/ready stream; master is the reader, slave is FIFO + consumer.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic                  fifo_read_en;
    logic [DATA_WIDTH-1:0] fifo_read_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty,
        input  fifo_read_data,
        input  m_ready,
        output fifo_read_en,
        output m_valid,
        output m_data
    );

    modport slave (
        output fifo_empty,
        output fifo_read_data,
        output m_ready,
        input  fifo_read_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_stream_reader_stream_skid_buf.sv
// Show-ahead buffer: head entry is presented combinationally; pointers carry a wrap bit.
module stream_skid_buf
    import fifo_stream_reader_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  DEPTH      = 2,
    localparam int IW         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW         = count_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  valid,
    output logic [CW-1:0]         count
);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [IW-1:0]         wr_idx, rd_idx;
    logic                  wr_wrap, rd_wrap;
    logic                  full, empty;

    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] idx);
        return (idx == IW'(DEPTH - 1)) ? '0 : idx + 1'b1;
    endfunction

    assign full    = (wr_idx == rd_idx) && (wr_wrap != rd_wrap);
    assign empty   = (wr_idx == rd_idx) && (wr_wrap == rd_wrap);
    assign valid   = !empty;
    assign rd_data = mem[rd_idx];

    always_comb begin
        if (wr_wrap == rd_wrap)
            count = CW'(wr_idx) - CW'(rd_idx);
        else
            count = CW'(DEPTH) - CW'(rd_idx) + CW'(wr_idx);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (clear) begin
            wr_idx  <= '0;
            rd_idx  <= '0;
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
        end else begin
            if (wr_en) begin
                mem[wr_idx] <= wr_data;
                wr_idx      <= next_idx(wr_idx);
                if (wr_idx == IW'(DEPTH - 1))
                    wr_wrap <= !wr_wrap;
            end
            if (rd_en) begin
                rd_idx <= next_idx(rd_idx);
                if (rd_idx == IW'(DEPTH - 1))
                    rd_wrap <= !rd_wrap;
            end
        end
    end

    // The upstream credit rule guarantees no write lands on a full buffer unless a read frees it.
    assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full && !rd_en && !clear));

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for util FIFOs: credit-limited pops into a show-ahead buffer, valid/ready out.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int  DATA_WIDTH = 8,
    parameter int  BUF_DEPTH  = 2,
    localparam int CW         = count_width(BUF_DEPTH),
    localparam int SW         = CW + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush,
    output logic [CW-1:0]           buf_count,
    fifo_stream_reader_if.master    bus
);
    generate
        if (BUF_DEPTH < 2) begin : g_depth_check
            $error("fifo_stream_reader: BUF_DEPTH must be at least 2");
        end
    endgenerate

    logic          inflight;
    logic          discard;
    logic          pop;
    logic          wr_en;
    logic          buf_valid;
    logic [SW-1:0] credit;

    assign pop    = buf_valid & bus.m_ready;
    // One bit wider than buf_count so count + inflight never wraps before the compare.
    assign credit = {1'b0, buf_count} + SW'(inflight) - SW'(pop);

    assign bus.fifo_read_en = rst_n & ~bus.fifo_empty & ~flush & (credit < SW'(BUF_DEPTH));
    assign wr_en            = inflight & ~discard & ~flush;
    assign bus.m_valid      = buf_valid;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            discard  <= 1'b0;
        end else begin
            inflight <= bus.fifo_read_en;
            discard  <= flush & inflight;
        end
    end

    stream_skid_buf #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (BUF_DEPTH)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (flush),
        .wr_en   (wr_en),
        .wr_data (bus.fifo_read_data),
        .rd_en   (pop),
        .rd_data (bus.m_data),
        .valid   (buf_valid),
        .count   (buf_count)
    );

endmodule
